// File: rtl/debounce_array_if.sv
// Signal bundle between the raw board inputs and the debounced outputs of debounce_array.
// The debouncer takes the slave side; whoever drives the buttons takes the master side.
interface debounce_array_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] buttons_raw;
    logic [NUM_CH-1:0] button_state;
    logic [NUM_CH-1:0] pressed_pulse;
    logic [NUM_CH-1:0] released_pulse;
    logic [NUM_CH-1:0] held_pulse;

    modport master (
        output buttons_raw,
        input  button_state,
        input  pressed_pulse,
        input  released_pulse,
        input  held_pulse
    );

    modport slave (
        input  buttons_raw,
        output button_state,
        output pressed_pulse,
        output released_pulse,
        output held_pulse
    );
endinterface

// File: rtl/debounce_array.sv
// Multi-channel button debouncer: 2-flop synchroniser, stability counter, and
// registered press / release / long-press pulses per channel.
module debounce_array #(
    parameter int NUM_CH       = 4,
    parameter int DELAY_COUNTS = 2500,
    parameter int HOLD_COUNTS  = 50000000,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    debounce_array_if.slave  io
);
    localparam int          CW        = $clog2(DELAY_COUNTS + 1);
    localparam logic [CW-1:0] DELAY_MAX = CW'(DELAY_COUNTS);
    localparam logic        INV       = (ACTIVE_LOW != 0);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic          r_meta;
        logic          r_sync2;
        logic          r_cand;
        logic [CW-1:0] r_count;
        logic          r_state;
        logic          r_press;
        logic          r_rel;
        logic          w_sync;
        logic          w_accept;

        assign w_sync   = r_sync2 ^ INV;
        assign w_accept = (w_sync == r_cand) && (r_count == DELAY_MAX) && (r_cand != r_state);

        // NOTE: synchroniser flops reset to the raw idle level so a released
        // active-low input does not look like a press when reset lifts.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta  <= INV;
                r_sync2 <= INV;
                r_cand  <= 1'b0;
                r_count <= '0;
                r_state <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_meta  <= io.buttons_raw[g];
                r_sync2 <= r_meta;
                if (w_sync != r_cand) begin
                    r_cand  <= w_sync;
                    r_count <= '0;
                end else if (r_count < DELAY_MAX) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_accept) begin
                    r_state <= r_cand;
                end
                r_press <= w_accept & r_cand;
                r_rel   <= w_accept & ~r_cand;
            end
        end

        assign io.button_state[g]   = r_state;
        assign io.pressed_pulse[g]  = r_press;
        assign io.released_pulse[g] = r_rel;

        if (HOLD_COUNTS > 0) begin : g_hold
            localparam int          HW        = $clog2(HOLD_COUNTS + 1);
            localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNTS - 1);
            localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_COUNTS);

            logic [HW-1:0] r_hold_cnt;
            logic          r_hold_done;
            logic          r_held;

            // The counter is already zero during the press-pulse cycle, so the
            // pulse lands exactly HOLD_COUNTS cycles after pressed_pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold_cnt  <= '0;
                    r_hold_done <= 1'b0;
                    r_held      <= 1'b0;
                end else begin
                    r_held <= 1'b0;
                    if (!r_state) begin
                        r_hold_cnt  <= '0;
                        r_hold_done <= 1'b0;
                    end else if (!r_hold_done && !w_accept) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_hold_cnt  <= HOLD_MAX;
                            r_hold_done <= 1'b1;
                            r_held      <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
            end

            assign io.held_pulse[g] = r_held;
        end else begin : g_no_hold
            assign io.held_pulse[g] = 1'b0;
        end
    end
endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
- Parametrised, multi-channel successor to the single-button debouncer, for the board-level button and switch inputs of the waiter FPGA.
- Each channel synchronises one raw input, then filters bounce with a per-channel stability counter.
- Each channel exports a debounced level plus single-cycle press, release and long-press event pulses for the downstream control FSMs and the FPGA-to-NANO command logic.

Parameters:
NUM_CH, 4, number of independent input channels (>=1)
DELAY_COUNTS, 2500, consecutive stable cycles required before accepting a new level (50 us at 20 ns clk; >=1)
HOLD_COUNTS, 50000000, cycles a debounced press must persist before held_pulse fires (1 s at 20 ns); 0 disables long-press detection
ACTIVE_LOW, 0, 1 = raw inputs are active-low and are inverted after synchronisation; all outputs are always active-high

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous, active-low reset
buttons_raw  input  NUM_CH  raw asynchronous button/switch inputs, bit i = channel i
button_state  output  NUM_CH  debounced level per channel (1 = pressed)
pressed_pulse  output  NUM_CH  one-cycle pulse on each debounced 0->1
released_pulse  output  NUM_CH  one-cycle pulse on each debounced 1->0
held_pulse  output  NUM_CH  one-cycle pulse when a press has lasted HOLD_COUNTS cycles

Behaviour:
- Reset: asserting rst_n low clears, immediately and asynchronously:
  - both synchroniser flops, candidate, count, state, hold counter and hold-done flag of every channel, all to the inactive value;
  - all outputs to 0.
- Reset release: no pulse is generated on deassertion, even if an input is held. A held input produces pressed_pulse after the normal debounce latency.
- Synchroniser: 2-flop per channel. After the second flop, XOR with ACTIVE_LOW gives sync[i].
- Counter width: $clog2(DELAY_COUNTS+1), so DELAY_COUNTS itself is representable for every value, including powers of two.
- Per channel, each clk edge:
  - if sync != candidate: candidate <= sync, count <= 0;
  - else if count < DELAY_COUNTS: count <= count+1;
  - else: count holds (saturates).
- Accept condition: accept = (sync == candidate) && (count == DELAY_COUNTS) && (candidate != state). On accept: state <= candidate.
- Pulses: pressed_pulse/released_pulse are registered, high for exactly the first cycle in which button_state shows the new value. They are never high together on one channel.
- Latency: a clean input step sampled at edge k changes button_state at edge k+DELAY_COUNTS+3. The bench checks this exact figure.
- Glitch rejection: any excursion stable for fewer than DELAY_COUNTS+1 synchronised cycles leaves state unchanged and produces no pulses.
- Hold logic (generated only when HOLD_COUNTS>0; otherwise held_pulse is tied 0):
  - hold counter width is $clog2(HOLD_COUNTS+1);
  - counter clears while state=0 and in the cycle of pressed_pulse;
  - counter increments while state=1 and the hold-done flag is clear;
  - when counter==HOLD_COUNTS: held_pulse for one cycle, hold-done set, counter stops;
  - hold-done clears on release;
  - at most one held_pulse per press; no auto-repeat.
- Release before HOLD_COUNTS: no held_pulse.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset mid-count or mid-hold: all progress is discarded, with no partial or late pulse after release.

Test Plan:
(Bench override: DELAY_COUNTS=4, HOLD_COUNTS=20, NUM_CH=4.)
1. Clean press: ch0 0->1 sampled at edge 10, held -> button_state[0]=1 and pressed_pulse[0]=1 at edge 17 only. Release the same way -> released_pulse[0] at +7 edges.
2. Bounce: ch1 toggles every 2 cycles for 20 cycles, then stable 1 -> exactly one pressed_pulse[1], 7 edges after the last toggle. No pulses during the bounce.
3. Long press: ch2 held 40 cycles past acceptance -> held_pulse[2] exactly once, 20 cycles after pressed_pulse[2]. A second press with a 10-cycle hold -> no held_pulse.
4. Reset mid-operation: rst_n low for 3 cycles while ch3 is at count 3 and ch0 is mid-hold, with inputs still pressed -> all outputs 0 immediately. After release, pressed_pulse fires at +7 edges for each held channel; no held_pulse leaks from the pre-reset hold.
5. Multi-channel: all 4 inputs rise on the same edge -> pressed_pulse=4'b1111 in one cycle.
6. ACTIVE_LOW=1 instance: input driven 1 from reset start -> button_state stays 0. Input falls to 0 -> pressed_pulse after 7 edges.
